// File: rtl/adder_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed slice adder.
// Contents: FSM state enum, slice-count and id-width helper functions.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Number of SLICE_W-bit steps needed to cover a DATA_W-bit operand.
    function automatic int unsigned num_slices(input int unsigned data_w,
                                               input int unsigned slice_w);
        return data_w / slice_w;
    endfunction

    // Width of an encoded requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req         - per-requester request vector
//   enable      - gates the grant outputs (zero grant when low)
//   advance     - a grant was taken; move the pointer to grant_idx
//   grant       - one-hot (or zero) grant
//   grant_idx   - encoded index of the granted requester (0 when none)
module adder_rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic                            enable,
    input  logic                            advance,
    output logic [NUM_REQ-1:0]              grant,
    output logic [id_width(NUM_REQ)-1:0]    grant_idx
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [IdW-1:0] last_q, last_d;
    logic [IdW:0]   wide;
    logic [IdW-1:0] idx;
    logic           found;

    // Search starts one past the last winner so it becomes lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        wide      = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wide = {1'b0, last_q} + (IdW + 1)'(1) + (IdW + 1)'(i);
            if (wide >= (IdW + 1)'(NUM_REQ)) begin
                wide = wide - (IdW + 1)'(NUM_REQ);
            end
            idx = wide[IdW-1:0];
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant_idx;
        end
    end

    // Reset to the highest index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IdW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/adder_slice_scheduler.sv
// Shares one SLICE_W-bit adder among NUM_REQ requesters: round-robin accept,
// then DATA_W/SLICE_W cycles of LSB-first slice addition with registered carry,
// then a held valid/ready response tagged with the requester id.
// Optional macro ADDER_SLICE_SCHED_SUB_EN adds req_sub: a set bit turns the
// operation into A-B (resp_carry=1 means no borrow).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          - packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_sub               - per-requester subtract select (macro only)
//   resp_valid/resp_ready - response handshake
//   resp_id, resp_sum, resp_carry - result, held stable while resp_valid
//   busy                  - operation in progress or awaiting response
module adder_slice_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SLICE_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
`ifdef ADDER_SLICE_SCHED_SUB_EN
    input  logic [NUM_REQ-1:0]              req_sub,
`endif
    input  logic [NUM_REQ*DATA_W-1:0]       req_a,
    input  logic [NUM_REQ*DATA_W-1:0]       req_b,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [id_width(NUM_REQ)-1:0]    resp_id,
    output logic [DATA_W-1:0]               resp_sum,
    output logic                            resp_carry,
    output logic                            busy
);

    localparam int unsigned NumSlices = num_slices(DATA_W, SLICE_W);
    localparam int unsigned IdW       = id_width(NUM_REQ);
    localparam int unsigned SliceIdxW = (NumSlices > 1) ? $clog2(NumSlices) : 1;

    if (DATA_W % SLICE_W != 0) begin : g_bad_width
        $error("DATA_W must be an integer multiple of SLICE_W");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IdW-1:0]         id_q, id_d;
    logic [SliceIdxW-1:0]   slice_q, slice_d;
    logic                   carry_q, carry_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IdW-1:0]         grant_idx;
    logic                   arb_en, accept, slice_last, sel_sub;
    logic [DATA_W-1:0]      sel_a, sel_b;
    logic [SLICE_W-1:0]     a_slice, b_slice;
    logic [SLICE_W:0]       slice_sum;
    int unsigned            lsb;

    assign arb_en = (state_q == StIdle);
    // grant is already qualified by req_valid, so any grant is a handshake.
    assign accept = |grant;

    adder_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .enable    (arb_en),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_a = req_a[32'(grant_idx) * DATA_W +: DATA_W];
    assign sel_b = req_b[32'(grant_idx) * DATA_W +: DATA_W];
`ifdef ADDER_SLICE_SCHED_SUB_EN
    assign sel_sub = req_sub[grant_idx];
`else
    assign sel_sub = 1'b0;
`endif

    assign slice_last = (slice_q == SliceIdxW'(NumSlices - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            slice_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            slice_q <= slice_d;
            carry_q <= carry_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)     state_d = StRun;
            StRun:   if (slice_last) state_d = StDone;
            StDone:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: capture on accept, one slice per RUN cycle.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        id_d      = id_q;
        slice_d   = slice_q;
        carry_d   = carry_q;
        lsb       = 32'(slice_q) * SLICE_W;
        a_slice   = a_q[lsb +: SLICE_W];
        b_slice   = b_q[lsb +: SLICE_W];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE_W{1'b0}}, carry_q};
        if (state_q == StIdle && accept) begin
            a_d     = sel_a;
            // Subtract is A + ~B + 1: invert B and seed the carry.
            b_d     = sel_sub ? ~sel_b : sel_b;
            carry_d = sel_sub;
            id_d    = grant_idx;
            slice_d = '0;
        end else if (state_q == StRun) begin
            sum_d[lsb +: SLICE_W] = slice_sum[SLICE_W-1:0];
            carry_d               = slice_sum[SLICE_W];
            slice_d               = slice_q + SliceIdxW'(1);
        end
    end

    // Outputs
    always_comb begin
        req_ready  = grant;
        resp_valid = (state_q == StDone);
        busy       = (state_q != StIdle);
        resp_id    = id_q;
        resp_sum   = sum_q;
        resp_carry = carry_q;
    end

endmodule

// File: tb/tb_adder_slice_scheduler.sv
// Scoreboard bench for adder_slice_scheduler (NUM_REQ=2, DATA_W=32, SLICE_W=8).
// Build with ADDER_SLICE_SCHED_SUB_EN to also cover subtraction.
module tb_adder_slice_scheduler;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        carry;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_sub = '0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [0:0]  resp_id;
    logic [31:0] resp_sum;
    logic        resp_carry;
    logic        busy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_slice_scheduler #(
        .NUM_REQ (2),
        .DATA_W  (32),
        .SLICE_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
`ifdef ADDER_SLICE_SCHED_SUB_EN
        .req_sub    (req_sub),
`endif
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .busy       (busy)
    );

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Monitor: every response handshake is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_resp", "response presented, none expected");
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(resp_id), 64'(e.id));
                check("resp_sum", 64'(resp_sum), 64'(e.sum));
                check("resp_carry", 64'(resp_carry), 64'(e.carry));
            end
        end
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output int acc);
        bit got;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_sub[id]        = sub;
        req_valid[id]      = 1'b1;
        got = 1'b0;
        acc = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("accept_timeout", "no req_ready within 100 cycles");
        acc = cyc;
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) fail_now("resp_timeout", "no resp_valid within 50 cycles");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, prev_acc, n;
        bit got;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_sum", 64'(resp_sum), 64'd0);
        check("rst_resp_carry", 64'(resp_carry), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op with latency check
        sb.push_back('{0, 32'h0000_0100, 1'b0});
        issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, acc);
        @(negedge clk);
        check("busy_run", 64'(busy), 64'd1);
        wait_valid(got);
        if (got) check("latency", 64'(cyc - acc), 64'd5);

        // Overflow / wrap-around
        sb.push_back('{1, 32'h0000_0000, 1'b1});
        issue(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
        sb.push_back('{0, 32'h0000_0000, 1'b1});
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, acc);

        // Backpressure with another requester waiting
        sb.push_back('{1, 32'h2345_6789, 1'b0});
        issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0, acc);
        resp_ready        = 1'b0;
        req_a[31:0]       = 32'h00FF_00FF;
        req_b[31:0]       = 32'h0001_0001;
        req_valid[0]      = 1'b1;
        sb.push_back('{0, 32'h0100_0100, 1'b0});
        wait_valid(got);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_sum", 64'(resp_sum), 64'h2345_6789);
            check("bp_id", 64'(resp_id), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_idle_grant", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;

        // Reset mid-op: abort during slice 2, no response expected
        issue(0, 32'h1111_1111, 32'h2222_2222, 1'b0, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        check("busy_before_rst", 64'(busy), 64'd1);
        req_a     = {32'hF0F0_F0F0, 32'h0000_000A};
        req_b     = {32'h0F0F_0F10, 32'h0000_0005};
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_resp_sum", 64'(resp_sum), 64'd0);
        check("mid_rst_resp_carry", 64'(resp_carry), 64'd0);
        check("mid_rst_resp_id", 64'(resp_id), 64'd0);
        check("mid_rst_first_grant", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fairness: both held valid, grants must alternate 0,1,0,1
        sb.push_back('{0, 32'h0000_000F, 1'b0});
        sb.push_back('{1, 32'h0000_0000, 1'b1});
        sb.push_back('{0, 32'h0000_000F, 1'b0});
        sb.push_back('{1, 32'h0000_0000, 1'b1});
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(|req_ready) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!(|req_ready)) begin
                fail_now("fair_timeout", "no grant within 100 cycles");
                break;
            end
            check("fair_grant", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            if (k > 0) check("occupancy", 64'(cyc - prev_acc), 64'd6);
            prev_acc = cyc;
            @(posedge clk);
            #1;
            if (k == 3) req_valid = 2'b00;
        end

`ifdef ADDER_SLICE_SCHED_SUB_EN
        // Subtraction
        sb.push_back('{1, 32'hFFFF_FFFE, 1'b0});
        issue(1, 32'd5, 32'd7, 1'b1, acc);
        sb.push_back('{1, 32'h0000_0002, 1'b1});
        issue(1, 32'd7, 32'd5, 1'b1, acc);
        req_sub = '0;
`endif

        // Drain
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_slice_scheduler.md
Name: adder_slice_scheduler

Overview:
Time-multiplexes one SLICE_W-bit adder slice to perform DATA_W-bit additions for NUM_REQ requesters.
- Round-robin arbitration selects one requester per operation.
- Operands are captured, then summed least-significant slice first over DATA_W/SLICE_W cycles with a registered carry.
- The result is returned on a single valid/ready response channel tagged with the requester id.
- Sits between client blocks and a shared narrow adder, as the area-saving alternative to fully unrolled wide adders.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width
SLICE_W, 8, adder slice width; DATA_W must be an integer multiple, else elaboration error

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_id  output  clog2(NUM_REQ) (min 1)  index of requester that issued the op
resp_sum  output  DATA_W  sum modulo 2^DATA_W
resp_carry  output  1  carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, busy=0, state=IDLE, slice index=0, carry reg=0, RR pointer set so requester 0 has highest priority.
- NUM_SLICES = DATA_W/SLICE_W.
- IDLE:
  - Grant is combinational: the first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ.
  - req_ready is asserted only for the granted requester.
  - On the handshake, capture A, B and id; clear carry and slice index; update last_grant; go to RUN.
- RUN:
  - Each cycle, slice k computes {c, s} = A[k*SLICE_W +: SLICE_W] + B[same] + carry_reg.
  - Write s into result[k*SLICE_W +: SLICE_W] and c into carry_reg.
  - After slice NUM_SLICES-1, go to DONE.
- DONE:
  - resp_valid=1; resp_sum, resp_carry and resp_id are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE.
  - A new request is never accepted in the same cycle as the response handshake.
- Latency: accept at cycle T, resp_valid first high at T+NUM_SLICES+1. Minimum occupancy is NUM_SLICES+2 cycles per operation.
- req_ready is 0 in RUN and DONE. Requesters must hold req_valid and operands until accepted; operands are don't-care after acceptance.
- A requester whose req_valid drops before acceptance simply loses its turn; no state is kept.
- Simultaneous valids: strict round-robin. A requester granted last has lowest priority next time.
- rst in any state (including mid-RUN): the operation is discarded and all registers return to reset values on that edge; no response is emitted.
- Wrap-around: the final carry appears only on resp_carry; resp_sum wraps modulo 2^DATA_W.

Optional Feature:
Macro ADDER_SLICE_SCHED_SUB_EN.
- Defined:
  - Adds input port req_sub (NUM_REQ bits), captured on accept.
  - When the captured bit is 1, B is bitwise inverted and carry_reg initialises to 1, so the result is A-B.
  - resp_carry=1 means no borrow.
- Not defined: port absent; addition only; carry_reg always initialises to 0.

Decomposition:
- Package adder_sched_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam function for NUM_SLICES
  - id-width helper
- Sub-module adder_rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, enable, advance.
  - Outputs: one-hot grant and encoded index.
  - Owns the last_grant pointer, updated on advance.
- The slice adder stays inline as a single SLICE_W+1-bit addition.

Test Plan:
- Single op: req0, a=0x000000FF, b=0x00000001, accepted cycle T -> resp_valid at T+5, resp_sum=0x00000100, resp_carry=0, resp_id=0.
- Overflow: a=0xFFFFFFFF, b=0x00000001 -> resp_sum=0x00000000, resp_carry=1. Also a=0x80000000, b=0x80000000 -> sum 0, carry 1.
- Fairness: req0 and req1 valid continuously with distinct operands, resp_ready=1 -> grant order 0,1,0,1; each op occupies 6 cycles; resp_id alternates.
- Backpressure: resp_ready=0 for 3 cycles in DONE -> resp_valid, resp_sum, resp_id stable; req_ready stays 0; on resp_ready=1, back to IDLE next cycle.
- Reset mid-op: rst asserted during RUN slice 2 -> next cycle busy=0, resp_valid=0, all outputs 0; with both requests pending, first grant after reset goes to req0.
- With ADDER_SLICE_SCHED_SUB_EN: a=5, b=7, sub=1 -> resp_sum=0xFFFFFFFE, resp_carry=0. a=7, b=5, sub=1 -> 0x00000002, carry 1.
